countdown_drain: RTL and testbench

//   Saturating down-counter that drains a loaded value to zero and holds there.

---
 rtl/countdown_pkg.sv | 23 ++
 rtl/countdown_sat_sub.sv | 18 +
 rtl/countdown_drain.sv | 105 ++++++++++
 tb/tb_countdown_drain.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and saturating-subtract helper for the
// countdown_drain block.
//   state_t  : 2-bit state code; IDLE / RUN / DONE are legacy-compatible
//              localparam constants.
//   sat_sub  : returns max(a - b, 0), masked to 'width' bits.
package countdown_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Comparing before subtracting means the result can never wrap below zero.
  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (a > b) ? ((a - b) & mask) : 32'd0;
  endfunction

endpackage

// File: rtl/countdown_sat_sub.sv
// countdown_sat_sub: combinational next-count for the drain counter.
//   Parameters: WIDTH (count width), STEP (decrement amount).
//   Ports:
//     i_count       in   WIDTH  current count
//     o_count_next  out  WIDTH  max(i_count - STEP, 0)
module countdown_sat_sub
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] i_count,
  output logic [WIDTH-1:0] o_count_next
);

  assign o_count_next = WIDTH'(sat_sub(32'(i_count), STEP, WIDTH));

endmodule

// File: rtl/countdown_drain.sv
// countdown_drain: saturating down-counter loaded over a valid/ready handshake.
// Counts down by STEP per unpaused RUN cycle, saturates at 0, flags empty and
// pulses done for exactly one cycle.
//   Parameters: WIDTH (>= 2), STEP (1 .. 2**WIDTH-1).
//   Optional feature macro: COUNTDOWN_ABORT_EN (adds i_abort).
//   Ports:
//     i_clk         in   1      clock, posedge
//     i_rstn        in   1      asynchronous active-low reset
//     i_load_valid  in   1      load request, held until accepted
//     o_load_ready  out  1      high only in IDLE
//     i_load_value  in   WIDTH  start value, sampled on valid && ready
//     i_pause       in   1      freezes the count in RUN
//     i_abort       in   1      (COUNTDOWN_ABORT_EN only) RUN -> IDLE, no done
//     o_count       out  WIDTH  registered count
//     o_busy        out  1      high in RUN
//     o_empty       out  1      o_count == 0
//     o_done        out  1      one-cycle pulse (DONE state)
module countdown_drain
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_pause,
`ifdef COUNTDOWN_ABORT_EN
  input  logic             i_abort,
`endif
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_empty,
  output logic             o_done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_next;
  logic             abort;

`ifdef COUNTDOWN_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  countdown_sat_sub #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_sat_sub (
    .i_count      (count_q),
    .o_count_next (count_next)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (i_load_valid) begin
          count_d = i_load_value;
          state_d = (i_load_value == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort outranks both pause and the transition into DONE.
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (!i_pause) begin
          count_d = count_next;
          if (count_next == '0) state_d = DONE;
        end
      end
      DONE: begin
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign o_count      = count_q;
  assign o_load_ready = (state_q == IDLE);
  assign o_busy       = (state_q == RUN);
  assign o_done       = (state_q == DONE);
  assign o_empty      = (count_q == '0);

endmodule

// File: tb/tb_countdown_drain.sv
// Directed bench for countdown_drain: one STEP=1 instance and one STEP=3
// instance. Outputs are sampled 1 ns after each rising edge.
module tb_countdown_drain;

  logic       clk;
  logic       rstn;
  // STEP=1 instance
  logic       valid, pause, abort;
  logic [7:0] value;
  logic       ready, busy, empty, done;
  logic [7:0] count;
  // STEP=3 instance
  logic       valid3, pause3, abort3;
  logic [7:0] value3;
  logic       ready3, busy3, empty3, done3;
  logic [7:0] count3;

  int npass = 0;
  int ntot  = 0;

  countdown_drain #(.WIDTH(8), .STEP(1)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_load_valid (valid),
    .o_load_ready (ready),
    .i_load_value (value),
    .i_pause      (pause),
`ifdef COUNTDOWN_ABORT_EN
    .i_abort      (abort),
`endif
    .o_count      (count),
    .o_busy       (busy),
    .o_empty      (empty),
    .o_done       (done)
  );

  countdown_drain #(.WIDTH(8), .STEP(3)) dut3 (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_load_valid (valid3),
    .o_load_ready (ready3),
    .i_load_value (value3),
    .i_pause      (pause3),
`ifdef COUNTDOWN_ABORT_EN
    .i_abort      (abort3),
`endif
    .o_count      (count3),
    .o_busy       (busy3),
    .o_empty      (empty3),
    .o_done       (done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full status of the STEP=1 instance in one call.
  task automatic chk_all(input string tag, input logic [7:0] c, input logic b,
                         input logic d, input logic r, input logic e);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".ready"}, 32'(ready), 32'(r));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
  endtask

  initial begin
    rstn = 1'b0;
    valid = 1'b0; pause = 1'b0; abort = 1'b0; value = 8'd0;
    valid3 = 1'b0; pause3 = 1'b0; abort3 = 1'b0; value3 = 8'd0;

    // Reset state
    #3;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset.dut3_ready", 32'(ready3), 32'd1);
    #9 rstn = 1'b1;

    // Load 5, STEP=1: RUN for 5 cycles, count 5,4,3,2,1 then DONE with 0
    valid = 1'b1; value = 8'd5;
    tick();
    valid = 1'b0;
    chk_all("t1.load", 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk_all("t1.run", 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_all("t1.done", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("t1.idle", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // STEP=3, load 7: 7,4,1,0 with saturation at the last step
    valid3 = 1'b1; value3 = 8'd7;
    tick();
    valid3 = 1'b0;
    chk("t2.load", 32'(count3), 32'd7);
    tick();
    chk("t2.c4", 32'(count3), 32'd4);
    tick();
    chk("t2.c1", 32'(count3), 32'd1);
    chk("t2.busy", 32'(busy3), 32'd1);
    tick();
    chk("t2.sat", 32'(count3), 32'd0);
    chk("t2.done", 32'(done3), 32'd1);
    chk("t2.empty", 32'(empty3), 32'd1);
    tick();
    chk("t2.done_off", 32'(done3), 32'd0);
    chk("t2.hold0", 32'(count3), 32'd0);
    chk("t2.ready", 32'(ready3), 32'd1);
    tick();
    chk("t2.still0", 32'(count3), 32'd0);

    // Load 0: straight to DONE, never busy
    valid = 1'b1; value = 8'd0;
    tick();
    valid = 1'b0;
    chk_all("t3.done", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("t3.idle", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Load 4, pause 3 cycles at count 3
    valid = 1'b1; value = 8'd4;
    tick();
    valid = 1'b0;
    chk("t4.load", 32'(count), 32'd4);
    tick();
    chk("t4.c3", 32'(count), 32'd3);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("t4.paused", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    pause = 1'b0;
    tick();
    chk("t4.c2", 32'(count), 32'd2);
    tick();
    chk("t4.c1", 32'(count), 32'd1);
    tick();
    chk_all("t4.done", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();

    // Pause at count 1 blocks the step to zero and the DONE transition
    valid = 1'b1; value = 8'd1;
    tick();
    valid = 1'b0;
    pause = 1'b1;
    tick();
    chk_all("t4b.pause_at1", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    pause = 1'b0;
    tick();
    chk_all("t4b.done", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();

    // Load 200, hold another valid in RUN, then async reset mid-RUN
    valid = 1'b1; value = 8'd200;
    tick();
    value = 8'd9;
    chk("t5.load", 32'(count), 32'd200);
    tick();
    chk("t5.no_accept_run", 32'(count), 32'd199);
    tick();
    chk("t5.c198", 32'(count), 32'd198);
    #3 rstn = 1'b0;
    #1;
    chk_all("t5.async_rst", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2 rstn = 1'b1;
    tick();
    valid = 1'b0;
    chk("t5.accept_idle", 32'(count), 32'd9);
    chk("t5.no_done", 32'(done), 32'd0);
    for (int i = 8; i >= 1; i--) tick();
    chk("t5.c1", 32'(count), 32'd1);
    tick();
    chk_all("t5.done", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();

`ifdef COUNTDOWN_ABORT_EN
    // Load 10, abort together with pause at count 6
    valid = 1'b1; value = 8'd10;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6.c6", 32'(count), 32'd6);
    abort = 1'b1; pause = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0;
    chk_all("t6.aborted", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("t6.no_done", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    // Abort beats the RUN -> DONE transition
    valid = 1'b1; value = 8'd1;
    tick();
    valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_all("t6.abort_last", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t6.abort_last_no_done", 32'(done), 32'd0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
